i2s_rx_deframer: RTL and testbench
==================================

Name: i2s_rx_deframer

Overview:
- Receive-side deframer for the i2s0 link, directly downstream of the pad-level i2s0_clk / i2s0_sync / i2s0_rx pins.
- Oversamples the external bit clock, sync and data in the system clock domain and reassembles MSB-first left/right words.
- Buffers complete stereo frames in a small FIFO with a valid/ready interface for the CSR/DMA side of top.
- The system clock must be at least 4x the I2S bit clock.

Parameters:
- WIDTH, 24, bits per channel word.
- FIFO_DEPTH, 4, stereo frames buffered; must be a power of two, at least 2.
- LEVEL_W, 3, width of fifo_level; equals log2(FIFO_DEPTH)+1.

Ports:
- refclk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = receive; 0 = return to HUNT.
- i2s_clk  in  1  external bit clock, asynchronous.
- i2s_sync  in  1  external LR sync, asynchronous; 0 = left, 1 = right.
- i2s_rx  in  1  external serial data, asynchronous.
- rx_left  out  WIDTH  left word of the FIFO head frame.
- rx_right  out  WIDTH  right word of the FIFO head frame.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts the head frame when rx_valid & rx_ready.
- fifo_level  out  LEVEL_W  frames currently held.
- aligned  out  1  framer is locked to the sync.
- overflow  out  1  sticky: a frame was dropped because the FIFO was full.
- frame_err  out  1  sticky: a short word was detected.
- err_clear  in  1  single-cycle pulse; clears overflow and frame_err.

Behaviour:
- Reset (asynchronous): all outputs 0; FIFO empty; state HUNT; synchronizers, counters and shift registers cleared.
- Synchronization:
  - clk, sync and rx each pass through an identical 2-flop synchronizer, so they stay mutually aligned.
  - A third flop on clk gives rise detection. A rising edge is flagged 3 refclk cycles after the pin edge.
  - At each flagged edge, sync and data are sampled from the synchronizer outputs (the "bit event").
- States:
  - HUNT: aligned=0. On a bit event where sync goes 1->0, enter LEFT with bit count 0.
  - LEFT / RIGHT: aligned=1. Shift data into the channel shift register MSB-first. Increment the count, saturating at WIDTH; bits beyond WIDTH are ignored (truncation).
  - Standard (one-bit-delay) mode: on a bit event where sync changes, that event's bit is first appended to the current word. The word is then checked, and counting for the other channel starts at the next event.
- Word check:
  - count == WIDTH: the word is accepted.
  - count < WIDTH: frame_err is set, the partial frame is discarded, and the framer goes to RIGHT if sync=1, or to LEFT with the count restarted if sync=0. It stays aligned.
- Frame completion:
  - A frame completes when the RIGHT word is accepted at a 1->0 sync change.
  - On the next refclk cycle, {left, right} is pushed into the FIFO.
  - If the FIFO was empty, rx_valid rises one cycle after the push.
- FIFO:
  - Registered, FWFT: rx_left/rx_right show the head frame whenever rx_valid=1.
  - Pop on rx_valid & rx_ready; fifo_level updates the cycle after a push or pop.
  - Push while full with no pop in the same cycle: the frame is dropped, overflow=1, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both succeed and the level stays FIFO_DEPTH.
  - Push and pop in the same cycle while empty: no pop occurs, the push succeeds, and the level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
- Errors: overflow and frame_err stay set until err_clear. If err_clear coincides with a new error event in the same cycle, the flag remains set.
- enable=0: go to HUNT next cycle and discard the partial frame. FIFO contents, the pop path and the error flags remain operational.
- rst asserted mid-frame: immediate return to the reset state, including FIFO flush.

Optional Feature:
- Macro: I2S_RX_LEFT_JUSTIFIED_EN.
- Defined (left-justified format):
  - The bit event on which sync changes carries the MSB of the new channel.
  - The word check on the old channel happens before that bit is shifted.
  - HUNT enters LEFT and captures that event's bit as bit 0.
- Undefined: standard I2S one-bit delay, as described in Behaviour.

Test Plan:
- Nominal loopback: bit clock at refclk/8, sync toggling every 24 bit clocks, transmitter sending L=24'hA5C3F0, R=24'h0F1E2D -> after the first full frame, rx_valid=1, rx_left=24'hA5C3F0, rx_right=24'h0F1E2D, fifo_level=1, no error flags.
- Backpressure: rx_ready=0 for 6 frames (FIFO_DEPTH=4) -> fifo_level saturates at 4, overflow=1, and the first 4 frames pop out in order. err_clear -> overflow=0.
- Short word: one left half-frame of 20 bit clocks -> frame_err=1, that frame is never pushed, and the following frame is received correctly with aligned held at 1.
- Long word: 32 bit clocks per channel with WIDTH=24 -> the top 24 bits are captured, no frame_err.
- Reset and enable:
  - Assert rst mid-right-word with 2 frames queued -> all outputs 0 within the same cycle window; the first post-reset frame is correct.
  - Drop enable mid-frame -> aligned=0 the next cycle, queued frames are still poppable.
- Simultaneous push and pop at full, with rx_ready held 1 as a frame completes -> fifo_level stays 4, no overflow; with the macro defined, the nominal loopback still passes using the left-justified stimulus.

Source files
------------

// File: rtl/i2s_rx_deframer.sv
// I2S receive deframer: oversamples bit clock/sync/data, rebuilds MSB-first L/R words, queues frames in a FWFT FIFO.
// Define I2S_RX_LEFT_JUSTIFIED_EN for left-justified framing; default is standard one-bit-delay I2S.
module i2s_rx_deframer #(
  parameter int WIDTH      = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int LEVEL_W    = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               enable,
  input  logic               i2s_clk,
  input  logic               i2s_sync,
  input  logic               i2s_rx,
  output logic [WIDTH-1:0]   rx_left,
  output logic [WIDTH-1:0]   rx_right,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               aligned,
  output logic               overflow,
  output logic               frame_err,
  input  logic               err_clear
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

  state_t             state, state_n;
  logic               clk_s1, clk_s2, clk_s3, sync_s1, sync_s2, rx_s1, rx_s2;
  logic               sync_prev, bit_evt, sync_chg;
  logic [CNT_W-1:0]   cnt, cnt_n, app_cnt, chk_cnt, new_cnt;
  logic [WIDTH-1:0]   shreg, sh_n, app_sh, chk_sh, new_sh;
  logic [WIDTH-1:0]   left_hold, left_n;
  logic               left_ok, left_ok_n, push_req, push_n, ferr_set;
  logic [2*WIDTH-1:0] push_data, push_data_n;

  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               full, pop, do_push;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      {clk_s1, clk_s2, clk_s3} <= '0;
      {sync_s1, sync_s2}       <= '0;
      {rx_s1, rx_s2}           <= '0;
      sync_prev                <= 1'b0;
    end else begin
      {clk_s1, clk_s2, clk_s3} <= {i2s_clk, clk_s1, clk_s2};
      {sync_s1, sync_s2}       <= {i2s_sync, sync_s1};
      {rx_s1, rx_s2}           <= {i2s_rx, rx_s1};
      if (bit_evt) sync_prev <= sync_s2;
    end
  end

  assign bit_evt  = clk_s2 & ~clk_s3;
  assign sync_chg = bit_evt & (sync_s2 != sync_prev);
  assign aligned  = (state != HUNT);

  always_comb begin
    app_sh  = (cnt < CNT_W'(WIDTH)) ? {shreg[WIDTH-2:0], rx_s2} : shreg;
    app_cnt = (cnt < CNT_W'(WIDTH)) ? cnt + 1'b1 : cnt;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    // The sync-change bit is the new channel's MSB: check the old word first.
    chk_sh  = shreg;
    chk_cnt = cnt;
    new_sh  = {{(WIDTH-1){1'b0}}, rx_s2};
    new_cnt = CNT_W'(1);
`else
    chk_sh  = app_sh;
    chk_cnt = app_cnt;
    new_sh  = '0;
    new_cnt = '0;
`endif
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh_n        = shreg;
    left_n      = left_hold;
    left_ok_n   = left_ok;
    push_n      = 1'b0;
    push_data_n = push_data;
    ferr_set    = 1'b0;
    if (!enable) begin
      state_n   = HUNT;
      cnt_n     = '0;
      sh_n      = '0;
      left_ok_n = 1'b0;
    end else if (bit_evt) begin
      unique case (state)
        HUNT: if (sync_prev && !sync_s2) begin
          state_n   = LEFT;
          cnt_n     = new_cnt;
          sh_n      = new_sh;
          left_ok_n = 1'b0;
        end
        LEFT, RIGHT: if (!sync_chg) begin
          sh_n  = app_sh;
          cnt_n = app_cnt;
        end else begin
          cnt_n   = new_cnt;
          sh_n    = new_sh;
          state_n = sync_s2 ? RIGHT : LEFT;
          if (chk_cnt == CNT_W'(WIDTH)) begin
            if (state == LEFT) begin
              left_n    = chk_sh;
              left_ok_n = 1'b1;
            end else begin
              // Only a frame whose left word was also accepted is pushed.
              push_n      = left_ok & ~sync_s2;
              push_data_n = {left_hold, chk_sh};
              left_ok_n   = 1'b0;
            end
          end else begin
            ferr_set  = 1'b1;
            left_ok_n = 1'b0;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      cnt       <= '0;
      shreg     <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
      push_req  <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= sh_n;
      left_hold <= left_n;
      left_ok   <= left_ok_n;
      push_req  <= push_n;
      push_data <= push_data_n;
      if (ferr_set)       frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (err_clear)           overflow <= 1'b0;
    end
  end

  assign full     = (fifo_level == LEVEL_W'(FIFO_DEPTH));
  assign rx_valid = (fifo_level != '0);
  assign pop      = rx_valid & rx_ready;
  assign do_push  = push_req & (~full | pop);
  assign rx_left  = mem[rd_ptr][2*WIDTH-1:WIDTH];
  assign rx_right = mem[rd_ptr][WIDTH-1:0];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[PTR_W'(i)] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rx_deframer.sv
// Self-checking bench for i2s_rx_deframer: random I2S streams against a frame-level queue model.
module tb_i2s_rx_deframer;
  localparam int W  = 24;
  localparam int D  = 4;
  localparam int LW = 3;

  logic refclk = 1'b0, rst = 1'b0, enable = 1'b1;
  logic i2s_clk = 1'b0, i2s_sync = 1'b0, i2s_rx = 1'b0;
  logic rx_ready = 1'b0, err_clear = 1'b0;
  logic [W-1:0] rx_left, rx_right;
  logic rx_valid, aligned, overflow, frame_err;
  logic [LW-1:0] fifo_level;

  int checks = 0, errors = 0;
  logic [2*W-1:0] model_q[$], pend[$];
  logic [2*W:0]   obs[$];
  bit pend_ferr, exp_ovf, exp_ferr;
  bit q_dat[$], q_chn[$];

  always #5 refclk = ~refclk;

  i2s_rx_deframer #(.WIDTH(W), .FIFO_DEPTH(D), .LEVEL_W(LW)) dut (
    .refclk(refclk), .rst(rst), .enable(enable),
    .i2s_clk(i2s_clk), .i2s_sync(i2s_sync), .i2s_rx(i2s_rx),
    .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fifo_level(fifo_level), .aligned(aligned), .overflow(overflow),
    .frame_err(frame_err), .err_clear(err_clear)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] trunc_word(input logic [31:0] w, input int n);
    logic [31:0] t;
    t = w >> (n - W);
    return t[W-1:0];
  endfunction

  task automatic drive_bit(input bit s, input bit d, input bit mark);
    @(posedge refclk); #1;
    i2s_clk = 1'b0; i2s_sync = s; i2s_rx = d;
    repeat (3) @(posedge refclk);
    @(posedge refclk); #1;
    i2s_clk = 1'b1;
    repeat (3) @(posedge refclk);
    if (mark) begin
      #1 rx_ready = 1'b1;
      @(posedge refclk); #1 rx_ready = 1'b0;
    end
  endtask

  task automatic add_word(input logic [31:0] w, input int n, input bit ch);
    for (int i = n - 1; i >= 0; i--) begin
      q_dat.push_back(w[i]);
      q_chn.push_back(ch);
    end
  endtask

  task automatic add_frame(input logic [31:0] l, input int nl, input logic [31:0] r, input int nr);
    add_word(l, nl, 1'b0);
    add_word(r, nr, 1'b1);
    if (nl >= W && nr >= W) pend.push_back({trunc_word(l, nl), trunc_word(r, nr)});
    else pend_ferr = 1'b1;
  endtask

  task automatic start_burst();
    q_dat.delete(); q_chn.delete(); pend.delete(); pend_ferr = 1'b0;
    add_word(32'hF, 4, 1'b1);
  endtask

  task automatic send_stream(input int n, input int mark);
    for (int i = 0; i < n; i++) begin
      bit s;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
      s = q_chn[i];
`else
      s = (i + 1 < q_chn.size()) ? q_chn[i+1] : q_chn[i];
`endif
      drive_bit(s, q_dat[i], i == mark);
    end
    repeat (6) @(posedge refclk);
    #1;
  endtask

  task automatic send_all();
    add_word(32'h0, 2, 1'b0);
    send_stream(q_dat.size(), -1);
  endtask

  task automatic commit();
    foreach (pend[k]) begin
      if (model_q.size() < D) model_q.push_back(pend[k]);
      else exp_ovf = 1'b1;
    end
    if (pend_ferr) exp_ferr = 1'b1;
  endtask

  task automatic rehunt();
    @(posedge refclk); #1 enable = 1'b0;
    repeat (2) @(posedge refclk);
    #1 enable = 1'b1;
  endtask

  task automatic drain(input int n);
    obs.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge refclk);
      obs.push_back({rx_valid, rx_left, rx_right});
      rx_ready = 1'b1;
      @(posedge refclk); #1 rx_ready = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    @(posedge refclk); #1 err_clear = 1'b1;
    @(posedge refclk); #1 err_clear = 1'b0;
    exp_ovf = 1'b0; exp_ferr = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    @(negedge refclk);
    checks++;
    if ({rx_valid, fifo_level, aligned, overflow, frame_err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%b lvl=%0d al=%b ov=%b fe=%b, expected all 0",
               rx_valid, fifo_level, aligned, overflow, frame_err);
    end
    checks++;
    if ({rx_left, rx_right} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h expected 0/0", rx_left, rx_right);
    end
    @(posedge refclk); #1 rst = 1'b0;
  endtask

  task automatic test_nominal();
    rehunt();
    start_burst();
    add_frame(32'hA5C3F0, W, 32'h0F1E2D, W);
    send_all();
    commit();
    @(negedge refclk);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL nom_valid: got %b expected 1", rx_valid); end
    checks++;
    if (rx_left !== 24'hA5C3F0) begin errors++; $display("FAIL nom_left: got %h expected a5c3f0", rx_left); end
    checks++;
    if (rx_right !== 24'h0F1E2D) begin errors++; $display("FAIL nom_right: got %h expected 0f1e2d", rx_right); end
    checks++;
    if (fifo_level !== LW'(model_q.size())) begin
      errors++; $display("FAIL nom_level: got %0d expected %0d", fifo_level, model_q.size());
    end
    checks++;
    if ({overflow, frame_err} !== {exp_ovf, exp_ferr}) begin
      errors++; $display("FAIL nom_flags: got %b%b expected %b%b", overflow, frame_err, exp_ovf, exp_ferr);
    end
    drain(model_q.size());
    foreach (obs[k]) begin
      checks++;
      if (obs[k] !== {1'b1, model_q[k]}) begin
        errors++; $display("FAIL nom_pop%0d: got %h expected %h", k, obs[k], {1'b1, model_q[k]});
      end
    end
    model_q.delete();
  endtask

  task automatic test_random();
    for (int b = 0; b < 3; b++) begin
      int nf;
      nf = $urandom_range(1, 3);
      rehunt();
      start_burst();
      for (int f = 0; f < nf; f++) begin
        int nl, nr;
        nl = ($urandom_range(0, 3) == 0) ? $urandom_range(W + 1, 32) : W;
        nr = ($urandom_range(0, 3) == 0) ? $urandom_range(W + 1, 32) : W;
        add_frame($urandom(), nl, $urandom(), nr);
      end
      send_all();
      commit();
      @(negedge refclk);
      checks++;
      if (fifo_level !== LW'(model_q.size())) begin
        errors++; $display("FAIL rnd_level: got %0d expected %0d", fifo_level, model_q.size());
      end
      checks++;
      if ({overflow, frame_err, aligned} !== {exp_ovf, exp_ferr, 1'b1}) begin
        errors++; $display("FAIL rnd_flags: got %b%b%b expected %b%b1", overflow, frame_err, aligned, exp_ovf, exp_ferr);
      end
      drain(model_q.size());
      foreach (obs[k]) begin
        checks++;
        if (obs[k] !== {1'b1, model_q[k]}) begin
          errors++; $display("FAIL rnd_pop%0d: got %h expected %h", k, obs[k], {1'b1, model_q[k]});
        end
      end
      model_q.delete();
    end
  endtask

  task automatic test_backpressure();
    rehunt();
    start_burst();
    for (int f = 0; f < 6; f++) add_frame($urandom(), W, $urandom(), W);
    send_all();
    commit();
    @(negedge refclk);
    checks++;
    if (fifo_level !== LW'(D)) begin errors++; $display("FAIL bp_level: got %0d expected %0d", fifo_level, D); end
    checks++;
    if (overflow !== exp_ovf || exp_ovf !== 1'b1) begin
      errors++; $display("FAIL bp_overflow: got %b expected 1", overflow);
    end
    drain(model_q.size());
    foreach (obs[k]) begin
      checks++;
      if (obs[k] !== {1'b1, model_q[k]}) begin
        errors++; $display("FAIL bp_pop%0d: got %h expected %h", k, obs[k], {1'b1, model_q[k]});
      end
    end
    model_q.delete();
    @(negedge refclk);
    checks++;
    if ({rx_valid, fifo_level} !== '0) begin
      errors++; $display("FAIL bp_empty: got v=%b lvl=%0d expected 0/0", rx_valid, fifo_level);
    end
    pulse_clear();
    @(negedge refclk);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL bp_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_short_word();
    rehunt();
    start_burst();
    add_frame($urandom(), 20, $urandom(), W);
    add_frame($urandom(), W, $urandom(), W);
    send_all();
    commit();
    @(negedge refclk);
    checks++;
    if ({frame_err, aligned} !== {exp_ferr, 1'b1} || exp_ferr !== 1'b1) begin
      errors++; $display("FAIL short_flags: got fe=%b al=%b expected 1/1", frame_err, aligned);
    end
    checks++;
    if (fifo_level !== LW'(model_q.size())) begin
      errors++; $display("FAIL short_level: got %0d expected %0d", fifo_level, model_q.size());
    end
    drain(model_q.size());
    foreach (obs[k]) begin
      checks++;
      if (obs[k] !== {1'b1, model_q[k]}) begin
        errors++; $display("FAIL short_pop%0d: got %h expected %h", k, obs[k], {1'b1, model_q[k]});
      end
    end
    model_q.delete();
    pulse_clear();
    @(negedge refclk);
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL short_clear: got %b expected 0", frame_err); end
  endtask

  task automatic test_long_word();
    rehunt();
    start_burst();
    add_frame($urandom(), 32, $urandom(), 32);
    send_all();
    commit();
    @(negedge refclk);
    checks++;
    if ({frame_err, fifo_level} !== {1'b0, LW'(1)}) begin
      errors++; $display("FAIL long_state: got fe=%b lvl=%0d expected 0/1", frame_err, fifo_level);
    end
    checks++;
    if ({rx_left, rx_right} !== model_q[0]) begin
      errors++; $display("FAIL long_data: got %h%h expected %h", rx_left, rx_right, model_q[0]);
    end
    drain(1);
    model_q.delete();
  endtask

  task automatic test_reset_mid();
    rehunt();
    start_burst();
    add_frame($urandom(), W, $urandom(), W);
    add_frame($urandom(), W, $urandom(), W);
    add_word($urandom(), W, 1'b0);
    add_word($urandom(), W, 1'b1);
    add_word(32'h0, 2, 1'b0);
    send_stream(4 + 4 * W + W + 10, -1);
    @(negedge refclk);
    checks++;
    if (fifo_level !== LW'(pend.size())) begin
      errors++; $display("FAIL rstmid_pre: got %0d expected %0d", fifo_level, pend.size());
    end
    @(posedge refclk); #2 rst = 1'b1;
    #1;
    checks++;
    if ({rx_valid, fifo_level, aligned, overflow, frame_err, rx_left, rx_right} !== '0) begin
      errors++; $display("FAIL rstmid_zero: got v=%b lvl=%0d al=%b data=%h%h expected all 0",
                         rx_valid, fifo_level, aligned, rx_left, rx_right);
    end
    @(posedge refclk); #1 rst = 1'b0;
    model_q.delete(); exp_ovf = 1'b0; exp_ferr = 1'b0;
    start_burst();
    add_frame($urandom(), W, $urandom(), W);
    send_all();
    commit();
    @(negedge refclk);
    checks++;
    if ({rx_valid, fifo_level, rx_left, rx_right} !== {1'b1, LW'(1), model_q[0]}) begin
      errors++; $display("FAIL rstmid_post: got v=%b lvl=%0d %h%h expected 1/1 %h",
                         rx_valid, fifo_level, rx_left, rx_right, model_q[0]);
    end
    drain(1);
    model_q.delete();
  endtask

  task automatic test_enable_drop();
    rehunt();
    start_burst();
    add_frame($urandom(), W, $urandom(), W);
    add_frame($urandom(), W, $urandom(), W);
    add_word($urandom(), W, 1'b0);
    add_word($urandom(), W, 1'b1);
    send_stream(4 + 4 * W + 12, -1);
    commit();
    enable = 1'b0;
    @(posedge refclk);
    @(negedge refclk);
    checks++;
    if (aligned !== 1'b0) begin errors++; $display("FAIL en_aligned: got %b expected 0", aligned); end
    drain(model_q.size());
    foreach (obs[k]) begin
      checks++;
      if (obs[k] !== {1'b1, model_q[k]}) begin
        errors++; $display("FAIL en_pop%0d: got %h expected %h", k, obs[k], {1'b1, model_q[k]});
      end
    end
    model_q.delete();
    #1 enable = 1'b1;
  endtask

  task automatic test_push_pop_full();
    int mark;
    rehunt();
    start_burst();
    for (int f = 0; f < D; f++) add_frame($urandom(), W, $urandom(), W);
    send_all();
    commit();
    rehunt();
    start_burst();
    add_frame($urandom(), W, $urandom(), W);
    add_word(32'h0, 2, 1'b0);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    mark = 4 + 2 * W;
`else
    mark = 4 + 2 * W - 1;
`endif
    send_stream(q_dat.size(), mark);
    void'(model_q.pop_front());
    model_q.push_back(pend[0]);
    @(negedge refclk);
    checks++;
    if ({fifo_level, overflow} !== {LW'(D), 1'b0}) begin
      errors++; $display("FAIL pp_full: got lvl=%0d ov=%b expected %0d/0", fifo_level, overflow, D);
    end
    drain(model_q.size());
    foreach (obs[k]) begin
      checks++;
      if (obs[k] !== {1'b1, model_q[k]}) begin
        errors++; $display("FAIL pp_pop%0d: got %h expected %h", k, obs[k], {1'b1, model_q[k]});
      end
    end
    model_q.delete();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_random();
    test_backpressure();
    test_short_word();
    test_long_word();
    test_reset_mid();
    test_enable_drop();
    test_push_pop_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
